// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: WIDTH shift-add or restoring-divide
// steps per operation, with a single registered write-back to the register file.
module muldiv_unit #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ADDR_SIZE-1:0] dest,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 wb_we,
  output logic [ADDR_SIZE-1:0] wb_addr,
  output logic [WIDTH-1:0]     result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           op_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     opnd_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [WIDTH-1:0]     result_reg;

  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;
  logic [WIDTH-1:0]     result_next;

  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Multiply: upper half accumulates the multiplicand, lower half holds the
  // remaining multiplier bits; the pair shifts right one bit per step.
  assign mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                    (prod_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_reg[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts the
  // dividend out and quotient bits in. A zero divisor naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  assign div_shift = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
  assign div_next  = {(div_ok ? div_diff : div_shift[WIDTH-1:0]),
                      prod_reg[WIDTH-2:0], div_ok};

  assign iter_next   = op_reg[1] ? div_next : mul_next;
  assign result_next = op_reg[0] ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start && !abort) state_next = S_RUN;
      S_RUN: begin
        if (abort)          state_next = S_IDLE;
        else if (last_iter) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg     <= 2'b00;
      cnt_reg    <= '0;
      opnd_reg   <= '0;
      prod_reg   <= '0;
      addr_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && !abort) begin
            op_reg   <= op;
            addr_reg <= dest;
            cnt_reg  <= '0;
            // Lower half seeds the multiplier (mul) or the dividend (div).
            prod_reg <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            opnd_reg <= op[1] ? b : a;
          end
        end
        S_RUN: begin
          if (!abort) begin
            prod_reg <= iter_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_iter) result_reg <= result_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign wb_we   = done;
  assign wb_addr = addr_reg;
  assign result  = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 32;
  localparam int ADDR_SIZE = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [ADDR_SIZE-1:0] dest;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 wb_we;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic [WIDTH-1:0]     result;

  muldiv_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .abort(abort), .busy(busy), .done(done), .wb_we(wb_we), .wb_addr(wb_addr),
    .result(result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [ADDR_SIZE-1:0] dest;
    logic [WIDTH-1:0]     exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    case (o)
      2'd0:    return p[WIDTH-1:0];
      2'd1:    return p[2*WIDTH-1:WIDTH];
      2'd2:    return (y == 0) ? {WIDTH{1'b1}} : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk); #1;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [ADDR_SIZE-1:0] d);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom); dest = ADDR_SIZE'($urandom);
    check("accept_busy", busy, 1);
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
      else if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [ADDR_SIZE-1:0] d,
                        input logic [WIDTH-1:0] exp);
    int   lat;
    logic bok;
    wait_idle();
    issue(o, x, y, d);
    wait_done(lat, bok);
    check({name, ".latency"}, lat, 16);
    check({name, ".busy_held"}, bok, 1);
    if (lat > 0) begin
      check({name, ".result"}, result, exp);
      check({name, ".wb_addr"}, wb_addr, d);
      check({name, ".wb_we"}, wb_we, 1);
      @(posedge clk); #1;
      check({name, ".done_pulse"}, done, 0);
      check({name, ".busy_end"}, busy, 0);
    end
    $display("%s op=%0d a=0x%04h b=0x%04h dest=%0d -> result=0x%04h (exp 0x%04h) lat=%0d",
             name, o, x, y, d, result, exp, lat);
  endtask

  initial begin
    int   lat;
    logic bok;
    logic seen;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [ADDR_SIZE-1:0] r_d;

    vecs[0] = '{2'd0, 16'h1234, 16'h0010, 5'd5,  16'h2340};
    vecs[1] = '{2'd1, 16'hFFFF, 16'hFFFF, 5'd6,  16'hFFFE};
    vecs[2] = '{2'd0, 16'hFFFF, 16'hFFFF, 5'd7,  16'h0001};
    vecs[3] = '{2'd2, 16'd100,  16'd7,    5'd8,  16'h000E};
    vecs[4] = '{2'd3, 16'd100,  16'd7,    5'd9,  16'h0002};
    vecs[5] = '{2'd2, 16'h1234, 16'h0000, 5'd10, 16'hFFFF};
    vecs[6] = '{2'd3, 16'h1234, 16'h0000, 5'd31, 16'h1234};

    start = 0; abort = 0; op = 0; a = 0; b = 0; dest = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.wb_we", wb_we, 0);
    check("reset.wb_addr", wb_addr, 0);
    check("reset.result", result, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp);

    // Back-to-back: start held high; the op change during RUN must be ignored,
    // and the second request is taken on the single IDLE cycle.
    wait_idle();
    op = 2'd2; a = 16'd100; b = 16'd7; dest = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    op = 2'd3; dest = 5'd4;
    wait_done(lat, bok);
    check("b2b.first_latency", lat, 16);
    check("b2b.first_result", result, 16'h000E);
    check("b2b.first_addr", wb_addr, 3);
    @(posedge clk); #1;
    check("b2b.idle_gap", busy, 0);
    @(posedge clk); #1;
    check("b2b.second_accept", busy, 1);
    start = 1'b0;
    wait_done(lat, bok);
    check("b2b.second_latency", lat, 16);
    check("b2b.second_result", result, 16'h0002);
    check("b2b.second_addr", wb_addr, 4);
    $display("b2b DIVU/REMU 100,7 -> 0x%04h", result);

    // start pulsed mid-operation is ignored
    wait_idle();
    issue(2'd0, 16'd3, 16'd4, 5'd1);
    repeat (4) begin @(posedge clk); #1; end
    op = 2'd2; a = 16'd7; b = 16'd9; dest = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bok);
    check("ignore.latency", lat, 11);
    check("ignore.result", result, 16'h000C);
    check("ignore.wb_addr", wb_addr, 1);
    $display("ignore MULL 3*4 with stray start -> 0x%04h", result);

    // abort during RUN
    wait_idle();
    issue(2'd1, 16'd5, 16'd6, 5'd9);
    repeat (7) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort.busy", busy, 0);
    seen = 1'b0;
    repeat (24) begin @(posedge clk); #1; if (done || wb_we) seen = 1'b1; end
    check("abort.no_done", seen, 0);
    check("abort.result_held", result, 16'h000C);
    check("abort.wb_addr", wb_addr, 9);
    $display("abort MULH 5*6 at cycle 8 -> result stays 0x%04h", result);

    // abort beats start in IDLE
    op = 2'd0; a = 16'd1; b = 16'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_vs_start.busy", busy, 0);

    // asynchronous reset mid-operation
    issue(2'd2, 16'hABCD, 16'd3, 5'd7);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.wb_we", wb_we, 0);
    check("midreset.result", result, 0);
    check("midreset.wb_addr", wb_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    $display("midreset DIVU 0xABCD/3 cancelled by reset");
    run_op("post_reset", 2'd0, 16'd2, 16'd3, 5'd6, 16'h0006);

    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       r_b = '0;
        1:       r_b = WIDTH'($urandom_range(1, 15));
        2:       r_b = {WIDTH{1'b1}};
        default: r_b = WIDTH'($urandom);
      endcase
      r_d = ADDR_SIZE'($urandom);
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, r_d, model(r_op, r_a, r_b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
